// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned MD_WIDTH = 32;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MULT = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Operation select (control unit MultOrDiv)
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit_abs_neg.sv
// Conditional two's-complement negate: res_c = neg ? -val_in : val_in.
module md_abs_neg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_in,
  input  logic             neg,
  output logic [WIDTH-1:0] res_c
);

  // Negate when requested, otherwise pass through
  always_comb begin
    res_c = neg ? (~val_in + WIDTH'(1)) : val_in;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit producing HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned ITER  = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mult_or_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);
  // One guard bit above WIDTH: keeps Booth add/sub of the most negative
  // multiplicand exact, and holds the restoring-divide trial difference sign.
  localparam int unsigned AW    = WIDTH + 1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;        // multiplicand / |divisor|
  logic [WIDTH-1:0] lo_w_q, lo_w_d;  // multiplier / dividend-then-quotient
  logic [AW-1:0]    acc_q, acc_d;    // Booth accumulator / partial remainder
  logic             q1_q, q1_d;      // Booth q(-1)
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [AW-1:0]    booth_sum;
  logic [AW-1:0]    div_shift;
  logic [AW-1:0]    div_diff;
  logic [WIDTH-1:0] neg0_in;
  logic [WIDTH-1:0] neg0_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic             b_zero;

  assign b_zero = (b_q == '0);

  // Shared negator: |dividend| while loading, signed remainder in FIX (both follow the dividend sign)
  assign neg0_in = (state_q == ST_FIX) ? acc_q[WIDTH-1:0] : a_q;

  md_abs_neg #(.WIDTH(WIDTH)) u_neg_a (
    .val_in (neg0_in),
    .neg    (a_q[WIDTH-1]),
    .res_c  (neg0_c)
  );

  md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
    .val_in (b_q),
    .neg    (b_q[WIDTH-1]),
    .res_c  (abs_b_c)
  );

  md_abs_neg #(.WIDTH(WIDTH)) u_neg_q (
    .val_in (lo_w_q),
    .neg    (a_q[WIDTH-1] ^ b_q[WIDTH-1]),
    .res_c  (quo_fix_c)
  );

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    lo_w_d    = lo_w_q;
    acc_d     = acc_q;
    q1_d      = q1_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    booth_sum = acc_q;
    div_shift = '0;
    div_diff  = '0;

    case (state_q)
      ST_IDLE: begin
        // A start landing in the div-by-zero done cycle is dropped
        if (start && !done_q) begin
          a_d   = a_in;
          b_d   = b_in;
          op_d  = mult_or_div;
          cnt_d = '0;
          if (mult_or_div == OP_MULT) begin
            state_d = ST_MULT;
          end else if (b_in != '0) begin
            state_d = ST_DIV;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_MULT, ST_DIV: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          // Load cycle: seed the working registers from the latched operands
          acc_d = '0;
          q1_d  = 1'b0;
          if (state_q == ST_MULT) begin
            m_d    = a_q;
            lo_w_d = b_q;
          end else begin
            m_d    = abs_b_c;
            lo_w_d = neg0_c;
          end
        end else if (state_q == ST_MULT) begin
          case ({lo_w_q[0], q1_q})
            2'b01:   booth_sum = acc_q + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum = acc_q - {m_q[WIDTH-1], m_q};
            default: booth_sum = acc_q;
          endcase
          acc_d  = {booth_sum[AW-1], booth_sum[AW-1:1]};
          lo_w_d = {booth_sum[0], lo_w_q[WIDTH-1:1]};
          q1_d   = lo_w_q[0];
        end else begin
          div_shift = {acc_q[WIDTH-1:0], lo_w_q[WIDTH-1]};
          div_diff  = div_shift - {1'b0, m_q};
          if (!div_diff[AW-1]) begin
            acc_d  = div_diff;
            lo_w_d = {lo_w_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d  = div_shift;
            lo_w_d = {lo_w_q[WIDTH-2:0], 1'b0};
          end
        end

        if (cnt_q == CNT_W'(ITER)) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FIX: begin
        busy_d  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_DONE;
        if (op_q == OP_DIV) begin
          hi_d = neg0_c;
          lo_d = quo_fix_c;
        end else begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = lo_w_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        // Divide-by-zero skips the datapath and signals from here
        if ((op_q == OP_DIV) && b_zero) begin
          busy_d = 1'b1;
          done_d = 1'b1;
          dz_d   = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      lo_w_q  <= '0;
      acc_q   <= '0;
      q1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      lo_w_q  <= lo_w_d;
      acc_q   <= acc_d;
      q1_q    <= q1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule
